dmem_fill: RTL
==============

DMEM_FILL -- requirements
Module: dmem_fill

Interface
REQ-001 SHALL have parameter LINE_W, default 256, meaning the L1 line width in bits; it SHALL be a multiple of 64.
REQ-002 SHALL have parameter BLK_W, default 59, meaning the block-address width, equal to 64-log2(LINE_W/8).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port b_addr_d, input, BLK_W bits: the L1 fill block address.
REQ-006 SHALL have port b_rd_d, input, 1 bit: the L1 fill request, held as a level.
REQ-007 SHALL have port b_data_in_d, output, LINE_W bits: the fill line.
REQ-008 SHALL have port b_dv_d, output, 1 bit: a one-cycle strobe meaning the fill line is valid.
REQ-009 SHALL have port m_addr, output, 64 bits: the backing-memory byte address, 8-byte aligned.
REQ-010 SHALL have port m_rd, output, 1 bit: the backing-memory beat request.
REQ-011 SHALL have port m_data, input, 64 bits: the backing-memory beat data.
REQ-012 SHALL have port m_ack, input, 1 bit: the beat-accepted/data-valid strobe.
REQ-013 SHALL have port snp_addr, input, 64 bits: the byte address of a foreign write-through store.
REQ-014 SHALL have port snp_wr, input, 1 bit: the snoop strobe.
REQ-015 SHALL have port inv_addr, output, BLK_W bits: the L1 invalidation block address.
REQ-016 SHALL have port inv, output, 1 bit: the one-cycle invalidation strobe.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, COLLECT, RESP.
REQ-018 In IDLE, b_rd_d=1 SHALL go to ADDR, because L1 registers b_addr_d one cycle after raising b_rd_d.
REQ-019 In ADDR, the block SHALL latch b_addr_d into blk_q, clear beat counter cnt and stale, then go to COLLECT; if b_rd_d has dropped it SHALL return to IDLE.
REQ-020 In COLLECT, the block SHALL drive m_rd=1 and m_addr={blk_q, cnt, 3'b000}; each m_ack SHALL write m_data into line lane cnt (lane 0 at LSB) and increment cnt.
REQ-021 The m_ack for the last beat (cnt=LINE_W/64-1) SHALL go to RESP if stale=0; if stale=1 it SHALL clear cnt and stale and stay in COLLECT (refetch).
REQ-022 In RESP, the block SHALL drive b_dv_d=1 for exactly one cycle with b_data_in_d held stable, then go to IDLE.
REQ-023 b_dv_d SHALL be 0 in all states except RESP.
REQ-024 IDLE SHALL NOT re-trigger on the cycle immediately after RESP, i.e. it needs b_rd_d low for at least one cycle after b_dv_d.
REQ-025 Fill latency, from b_rd_d rise to b_dv_d with zero-wait m_ack, SHALL be LINE_W/64+2 cycles (6 at default).
REQ-026 snp_wr=1 SHALL register inv=1 and inv_addr=snp_addr[63:64-BLK_W] on the next cycle; every snoop SHALL produce exactly one inv pulse, and back-to-back snoops SHALL produce back-to-back pulses.
REQ-027 A snoop whose block equals blk_q while in COLLECT SHALL set stale, so no line older than the store is returned.
REQ-028 A snoop matching blk_q in RESP SHALL still complete the response and SHALL still pulse inv on the following cycle, and L1 SHALL drop the line.
REQ-029 Deassertion of m_ack mid-COLLECT SHALL stall with no lane change.

Reset
REQ-030 rst SHALL force state IDLE, b_dv_d=0, m_rd=0, m_addr=0, inv=0, inv_addr=0, b_data_in_d=0, cnt=0, stale=0.
REQ-031 rst asserted mid-COLLECT SHALL abandon the fill, and the next cycle SHALL show m_rd=0.

Configuration
REQ-032 Macro DMEM_FILL_LBUF_EN, when defined, SHALL add a one-entry last-line buffer (tag, line, valid) written on each RESP.
REQ-033 With DMEM_FILL_LBUF_EN, ADDR SHALL go directly to RESP with no m_rd when valid and tag equals b_addr_d, giving a latency of 2 cycles.
REQ-034 With DMEM_FILL_LBUF_EN, a snoop matching the buffer tag, and rst, SHALL clear valid.
REQ-035 Without DMEM_FILL_LBUF_EN, every fill SHALL access memory.

Structure
REQ-036 The FSM state encoding, the beat-count width function and the BEAT_W=64 constant SHALL reside in shared package dmem_fill_pkg.
REQ-037 The last-line buffer SHALL be sub-module dmem_fill_lbuf, instantiated only under DMEM_FILL_LBUF_EN.

Verification
REQ-038 A bench SHALL cover: b_rd_d held, b_addr_d=0x10, m_ack always 1, beats 0xA..0xD -> m_addr 0x200,0x208,0x210,0x218; b_dv_d on cycle 6; line={0xD,0xC,0xB,0xA}.
REQ-039 A bench SHALL cover: the same fill with m_ack low for 3 cycles before beat 2 -> b_dv_d delayed 3 cycles and data unchanged.
REQ-040 A bench SHALL cover: snp_wr with snp_addr=0x208 during COLLECT of block 0x10 -> inv=1, inv_addr=0x10 next cycle; 8 beats issued; b_dv_d carries the second-pass data.
REQ-041 A bench SHALL cover: snp_wr on two consecutive cycles, addresses 0x40 and 0x80 -> inv pulses on two consecutive cycles with inv_addr 0x2 then 0x4.
REQ-042 A bench SHALL cover: rst pulsed after beat 1 -> m_rd=0 and b_dv_d=0; a new request completes normally.
REQ-043 A bench SHALL cover, with DMEM_FILL_LBUF_EN: a repeat fill of 0x10 -> b_dv_d 2 cycles after b_rd_d with m_rd never high; after a snoop to 0x200, a repeat fill of 0x10 -> full memory fetch.

Source files
------------

// File: rtl/dmem_fill_pkg.sv
// dmem_fill_pkg: FSM encoding, beat width and beat-counter width shared by dmem_fill and its buffer.
package dmem_fill_pkg;
    localparam int BEAT_W = 64;
    typedef enum logic [1:0] {IDLE, ADDR, COLLECT, RESP} state_e;
    function automatic int cnt_w(input int line_w);
        return (line_w / BEAT_W > 1) ? $clog2(line_w / BEAT_W) : 1;
    endfunction
endpackage

// File: rtl/dmem_fill_lbuf.sv
// dmem_fill_lbuf: one-entry last-line buffer (tag, line, valid), present only with DMEM_FILL_LBUF_EN.
// A snoop to the held block (or to the block being written) drops the entry.
`ifdef DMEM_FILL_LBUF_EN
module dmem_fill_lbuf #(
    parameter int LINE_W = 256,
    parameter int BLK_W  = 59
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_i,
    input  logic [BLK_W-1:0]  wr_tag_i,
    input  logic [LINE_W-1:0] wr_line_i,
    input  logic              snp_i,
    input  logic [BLK_W-1:0]  snp_blk_i,
    input  logic [BLK_W-1:0]  tag_i,
    output logic              hit_o,
    output logic [LINE_W-1:0] line_o
);
    logic [BLK_W-1:0]  tag_q;
    logic [LINE_W-1:0] line_q;
    logic              valid_q, valid_d;
    always_comb begin
        valid_d = wr_i ? !(snp_i && snp_blk_i == wr_tag_i)
                       : valid_q && !(snp_i && snp_blk_i == tag_q);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= '0;
            line_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (wr_i) begin
                tag_q  <= wr_tag_i;
                line_q <= wr_line_i;
            end
        end
    end
    assign hit_o  = valid_q && tag_q == tag_i;
    assign line_o = line_q;
endmodule
`endif

// File: rtl/dmem_fill.sv
// dmem_fill: L1 line-fill engine collecting 64-bit beats into a line, with snoop invalidation and refetch.
// Optional last-line buffer behind macro DMEM_FILL_LBUF_EN.
module dmem_fill
    import dmem_fill_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int BLK_W  = 59
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BLK_W-1:0]  b_addr_d,
    input  logic              b_rd_d,
    output logic [LINE_W-1:0] b_data_in_d,
    output logic              b_dv_d,
    output logic [63:0]       m_addr,
    output logic              m_rd,
    input  logic [63:0]       m_data,
    input  logic              m_ack,
    input  logic [63:0]       snp_addr,
    input  logic              snp_wr,
    output logic [BLK_W-1:0]  inv_addr,
    output logic              inv
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CW    = cnt_w(LINE_W);
    localparam int OFF_W = 64 - BLK_W;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    state_e            state_q, state_d;
    logic [BLK_W-1:0]  blk_q, blk_d, inv_addr_q, snp_blk;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d, lb_line;
    logic              stale_q, stale_d, arm_q, inv_q, snp_hit, lb_hit, refetch;
    logic              unused_snp;

    assign snp_blk    = snp_addr[63 -: BLK_W];
    assign snp_hit    = snp_wr && snp_blk == blk_q;
    assign unused_snp = ^snp_addr[OFF_W-1:0];

`ifdef DMEM_FILL_LBUF_EN
    dmem_fill_lbuf #(.LINE_W(LINE_W), .BLK_W(BLK_W)) u_lbuf (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (state_q == RESP),
        .wr_tag_i  (blk_q),
        .wr_line_i (line_q),
        .snp_i     (snp_wr),
        .snp_blk_i (snp_blk),
        .tag_i     (b_addr_d),
        .hit_o     (lb_hit),
        .line_o    (lb_line)
    );
`else
    assign lb_hit  = 1'b0;
    assign lb_line = '0;
`endif

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;
        stale_d = stale_q;
        line_d  = line_q;
        refetch = 1'b0;
        m_rd    = 1'b0;
        m_addr  = '0;
        b_dv_d  = 1'b0;
        case (state_q)
            IDLE: state_d = (b_rd_d && arm_q) ? ADDR : IDLE;
            ADDR: begin
                blk_d   = b_addr_d;
                cnt_d   = '0;
                stale_d = 1'b0;
                state_d = !b_rd_d ? IDLE : lb_hit ? RESP : COLLECT;
                line_d  = (b_rd_d && lb_hit) ? lb_line : line_q;
            end
            COLLECT: begin
                m_rd    = 1'b1;
                m_addr  = {blk_q, OFF_W'({cnt_q, 3'b000})};
                stale_d = stale_q | snp_hit;
                if (m_ack) begin
                    for (int l = 0; l < BEATS; l++)
                        if (cnt_q == CW'(l)) line_d[l*BEAT_W +: BEAT_W] = m_data;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // a store that raced this pass forces a full second pass
                        refetch = stale_d;
                        cnt_d   = '0;
                        stale_d = 1'b0;
                        state_d = refetch ? COLLECT : RESP;
                    end
                end
            end
            RESP: begin
                b_dv_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            blk_q      <= '0;
            cnt_q      <= '0;
            stale_q    <= 1'b0;
            line_q     <= '0;
            arm_q      <= 1'b1;
            inv_q      <= 1'b0;
            inv_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            cnt_q      <= cnt_d;
            stale_q    <= stale_d;
            line_q     <= line_d;
            arm_q      <= (state_q == RESP) ? 1'b0 : (arm_q | ~b_rd_d);
            inv_q      <= snp_wr;
            inv_addr_q <= snp_wr ? snp_blk : inv_addr_q;
        end
    end

    assign b_data_in_d = line_q;
    assign inv         = inv_q;
    assign inv_addr    = inv_addr_q;
endmodule
